// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: drives a HUB75 LED panel with 8-plane binary-coded modulation, one row pair at a time.
// Ports: clk/rst (async active-high); run enables scanning; top_rgb/bot_rgb are pixels arriving 1 cycle
// after fb_rd at fb_addr={row,col}; hub_* are the panel pins; frame_done pulses when the last row's last plane ends.
module hub75_bcm_scanner #(
  parameter int COLS = 64,
  parameter int ROW_BITS = 5,
  parameter int BASE_TICKS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run,
  input  logic [23:0]                         top_rgb,
  input  logic [23:0]                         bot_rgb,
  output logic                                fb_rd,
  output logic [ROW_BITS+$clog2(COLS)-1:0]    fb_addr,
  output logic                                hub_r1,
  output logic                                hub_g1,
  output logic                                hub_b1,
  output logic                                hub_r2,
  output logic                                hub_g2,
  output logic                                hub_b2,
  output logic                                hub_clk,
  output logic                                hub_lat,
  output logic                                hub_oe_n,
  output logic [ROW_BITS-1:0]                 hub_addr,
  output logic                                frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(BASE_TICKS * 128 + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;
  state_t state, state_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic [2:0] plane;
  logic [CW-1:0] col;
  logic [TW-1:0] ticks, disp_len;
  logic [4:0] pi;
  logic phase, stop, shift_end, disp_end, go;
  assign disp_len = TW'(BASE_TICKS) << plane;
  assign shift_end = state == SHIFT && phase && col == CW'(COLS - 1);
  assign disp_end = state == DISPLAY && ticks == disp_len - TW'(1);
  // stop remembers a run drop anywhere in the plane so the plane still finishes before idling
  assign go = run && !stop;
  assign row_n = plane == 3'd7 ? row + 1'b1 : row;
  assign pi = {2'b00, plane};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run) state_n = SHIFT;
      SHIFT:   if (shift_end) state_n = LATCH;
      LATCH:   state_n = DISPLAY;
      DISPLAY: if (disp_end) state_n = go ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // the read for each column is issued in the cycle before its phase 0; column 0's read comes from IDLE or the last DISPLAY cycle
  always_comb begin
    hub_clk = state == SHIFT && phase;
    hub_lat = state == LATCH;
    hub_oe_n = state != DISPLAY;
    frame_done = disp_end && plane == 3'd7 && &row;
    fb_rd = !rst && ((state == IDLE && run) || (state == SHIFT && phase && !shift_end) || (disp_end && go));
    fb_addr = fb_rd ? {disp_end ? row_n : row, state == SHIFT ? col + 1'b1 : CW'(0)} : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= '0;
      plane <= '0;
      col <= '0;
      phase <= 1'b0;
      ticks <= '0;
      stop <= 1'b0;
      hub_addr <= '0;
      {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} <= '0;
    end else begin
      phase <= state == SHIFT && !phase;
      col <= state != SHIFT ? '0 : col + CW'(phase);
      ticks <= state == DISPLAY && !disp_end ? ticks + 1'b1 : '0;
      stop <= state != IDLE && (stop || !run);
      if (disp_end) begin
        plane <= plane + 1'b1;
        row <= row_n;
      end
      if (shift_end) hub_addr <= row;
      if (state == SHIFT && !phase)
        {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} <=
          {top_rgb[pi + 5'd16], top_rgb[pi + 5'd8], top_rgb[pi], bot_rgb[pi + 5'd16], bot_rgb[pi + 5'd8], bot_rgb[pi]};
    end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: checks the scanner cycle by cycle against a plane/column/tick schedule model.
module tb_hub75_bcm_scanner;
  localparam int COLS = 64;
  localparam int RB = 5;
  localparam int BASE = 4;
  logic clk = 0, rst = 1, run = 0, rst_s = 1, run_s = 0;
  always #5 clk = ~clk;
  logic [23:0] top_rgb = 0, bot_rgb = 0;
  logic fb_rd, hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2, hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [10:0] fb_addr;
  logic [RB-1:0] hub_addr;
  logic fb_rd_s, r1_s, g1_s, b1_s, r2_s, g2_s, b2_s, hub_clk_s, hub_lat_s, hub_oe_n_s, frame_done_s;
  logic [2:0] fb_addr_s;
  logic [0:0] hub_addr_s;
  hub75_bcm_scanner #(.COLS(COLS), .ROW_BITS(RB), .BASE_TICKS(BASE)) dut (
    .clk(clk), .rst(rst), .run(run), .top_rgb(top_rgb), .bot_rgb(bot_rgb), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1), .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n), .hub_addr(hub_addr), .frame_done(frame_done));
  hub75_bcm_scanner #(.COLS(4), .ROW_BITS(1), .BASE_TICKS(1)) dut_s (
    .clk(clk), .rst(rst_s), .run(run_s), .top_rgb(24'h0), .bot_rgb(24'h0), .fb_rd(fb_rd_s), .fb_addr(fb_addr_s),
    .hub_r1(r1_s), .hub_g1(g1_s), .hub_b1(b1_s), .hub_r2(r2_s), .hub_g2(g2_s), .hub_b2(b2_s),
    .hub_clk(hub_clk_s), .hub_lat(hub_lat_s), .hub_oe_n(hub_oe_n_s), .hub_addr(hub_addr_s), .frame_done(frame_done_s));
  logic [23:0] mem_top [2048];
  logic [23:0] mem_bot [2048];
  always @(posedge clk)
    if (fb_rd) begin
      top_rgb <= mem_top[fb_addr];
      bot_rgb <= mem_bot[fb_addr];
    end
  typedef struct {
    logic [23:0] top;
    logic [23:0] bot;
    int plane;
    logic [5:0] colours;
  } vec_t;
  vec_t vecs[4];
  int tests = 0, fails = 0, shown = 0;
  logic [5:0] got_col0;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] actual();
    return {5'b0, fb_rd, fb_rd ? fb_addr : 11'h0, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done,
            hub_clk ? {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} : 6'h0};
  endfunction
  function automatic logic [31:0] model(bit rd, int addr, bit hc, bit lat, bit oe, int ha, bit fd, logic [5:0] col);
    return {5'b0, rd, rd ? 11'(addr) : 11'h0, hc, lat, oe, 5'(ha), fd, hc ? col : 6'h0};
  endfunction
  task automatic cmp(string name, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask
  function automatic logic [5:0] pix(int r, int c, int p);
    logic [23:0] t, b;
    t = mem_top[r * COLS + c];
    b = mem_bot[r * COLS + c];
    return {t[16 + p], t[8 + p], t[p], b[16 + p], b[8 + p], b[p]};
  endfunction
  task automatic check_plane(int r, int p, bit cont, int drop_at);
    int len, nr;
    len = BASE << p;
    nr = p == 7 ? (r + 1) % 32 : r;
    for (int c = 0; c < COLS; c++) begin
      step;
      cmp("shift_lo", actual(), model(0, 0, 0, 0, 1, shown, 0, 0));
      if (2 * c == drop_at) run = 0;
      step;
      cmp("shift_hi", actual(), model(c < COLS - 1, r * COLS + c + 1, 1, 0, 1, shown, 0, pix(r, c, p)));
      if (c == 0) got_col0 = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};
    end
    step;
    shown = r;
    cmp("latch", actual(), model(0, 0, 0, 1, 1, r, 0, 0));
    for (int t = 0; t < len; t++) begin
      step;
      cmp("display", actual(), model(t == len - 1 && cont, nr * COLS, 0, 0, 0, r, t == len - 1 && p == 7 && r == 31, 0));
    end
  endtask
  task automatic restart;
    rst = 1;
    #1;
    rst = 0;
    shown = 0;
    run = 1;
    #1;
    cmp("first_rd", actual(), model(1, 0, 0, 0, 1, 0, 0, 0));
  endtask
  initial begin
    int q[$];
    int frame;
    vecs[0] = '{24'hA53C0F, 24'h00FF80, 0, 6'b101010};
    vecs[1] = '{24'hA53C0F, 24'h00FF80, 7, 6'b100011};
    vecs[2] = '{24'hA53C0F, 24'h00FF80, 3, 6'b011010};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 5, 6'b111000};
    repeat (3) step;
    cmp("reset", actual(), model(0, 0, 0, 0, 1, 0, 0, 0));
    run = 1;
    #1;
    cmp("reset_run", actual(), model(0, 0, 0, 0, 1, 0, 0, 0));
    run = 0;
    rst = 0;
    step;
    cmp("idle", actual(), model(0, 0, 0, 0, 1, 0, 0, 0));
    for (int v = 0; v < 4; v++) begin
      for (int a = 0; a < 2048; a++) begin
        mem_top[a] = vecs[v].top;
        mem_bot[a] = vecs[v].bot;
      end
      restart;
      for (int p = 0; p <= vecs[v].plane; p++) check_plane(0, p, 1, -1);
      cmp("colour_map", 32'(got_col0), 32'(vecs[v].colours));
    end
    for (int a = 0; a < 2048; a++) begin
      mem_top[a] = 24'($urandom);
      mem_bot[a] = 24'($urandom);
    end
    restart;
    for (int p = 0; p < 8; p++) check_plane(0, p, 1, -1);
    check_plane(1, 0, 1, -1);
    check_plane(1, 1, 1, -1);
    check_plane(1, 2, 0, 6);
    repeat (4) begin
      step;
      cmp("idle_after_drop", actual(), model(0, 0, 0, 0, 1, 1, 0, 0));
    end
    run = 1;
    #1;
    cmp("resume_rd", actual(), model(1, COLS, 0, 0, 1, 1, 0, 0));
    check_plane(1, 3, 1, -1);
    repeat (2 * COLS + 1 + 3) step;
    cmp("in_display", {31'h0, hub_oe_n}, 32'h0);
    rst = 1;
    #1;
    cmp("rst_mid_display", actual(), model(0, 0, 0, 0, 1, 0, 0, 0));
    step;
    restart;
    check_plane(0, 0, 1, -1);
    frame = 0;
    for (int p = 0; p < 8; p++) frame += 2 * 4 + 1 + (1 << p);
    frame *= 2;
    rst_s = 0;
    run_s = 1;
    #1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (frame_done_s) q.push_back(cyc);
      if (cyc == frame / 2 + 9) cmp("s_row1_latch", {30'h0, hub_lat_s, hub_addr_s}, 32'h3);
      if (cyc == frame + 9) cmp("s_wrap_latch", {30'h0, hub_lat_s, hub_addr_s}, 32'h2);
      step;
    end
    cmp("s_pulse_count", 32'(q.size()), 32'd3);
    foreach (q[k]) cmp("s_pulse_at", 32'(q[k]), 32'(frame * (k + 1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
